// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res,
    output logic       carry,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_res,
    input  logic       alu_xtra
);

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    // Owner of the current/last operation; reset value 1 hands the first tie to requester 0.
    logic       r_last;
    logic       w_any;
    logic       w_sel;
    logic       w_cnt_zero;

    assign w_any      = req0 | req1;
    assign w_sel      = (req0 & req1) ? ~r_last : req1;
    assign w_cnt_zero = (r_cnt == 3'd0);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_EXEC;
            S_EXEC:  if (w_cnt_zero) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            res    <= 8'd0;
            carry  <= 1'b0;
            alu_a  <= 8'd0;
            alu_b  <= 8'd0;
            alu_op <= 3'd0;
            r_cnt  <= 3'd0;
            r_last <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        alu_a  <= w_sel ? a1 : a0;
                        alu_b  <= w_sel ? b1 : b0;
                        alu_op <= w_sel ? op1 : op0;
                        gnt0   <= ~w_sel;
                        gnt1   <= w_sel;
                        r_cnt  <= LAT;
                        r_last <= w_sel;
                    end
                end
                S_EXEC: begin
                    if (w_cnt_zero) begin
                        res   <= alu_res;
                        carry <= alu_xtra;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        done0 <= ~r_last;
                        done1 <= r_last;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter at ALU_LAT 1 and 3
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req0, req1, gnt0, gnt1, done0, done1, carry, busy, alu_xtra;
    logic [7:0] a0, b0, a1, b1, res, alu_a, alu_b, alu_res;
    logic [2:0] op0, op1, alu_op;

    logic       req0_3, req1_3, gnt0_3, gnt1_3, done0_3, done1_3, carry_3, busy_3, alu_xtra_3;
    logic [7:0] a0_3, b0_3, a1_3, b1_3, res_3, alu_a_3, alu_b_3, alu_res_3;
    logic [2:0] op0_3, op1_3, alu_op_3;

    alu_arbiter #(.ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .carry(carry), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_xtra(alu_xtra)
    );

    alu_arbiter #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req0(req0_3), .req1(req1_3),
        .a0(a0_3), .b0(b0_3), .a1(a1_3), .b1(b1_3), .op0(op0_3), .op1(op1_3),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3),
        .res(res_3), .carry(carry_3), .busy(busy_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3),
        .alu_res(alu_res_3), .alu_xtra(alu_xtra_3)
    );

    // Behavioural ALU: {extra, result}; extra is carry, borrow, or the bit shifted out.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a};
            3'd3:    return {a[7], a[6:0], 1'b0};
            3'd4:    return {a[0], 1'b0, a[7:1]};
            3'd5:    return {1'b0, a & b};
            3'd6:    return {1'b0, ~a};
            default: return {1'b0, a | b};
        endcase
    endfunction

    logic [8:0] p1, q1, q2, q3;
    always @(posedge clk) begin
        p1 <= alu_f(alu_a, alu_b, alu_op);
        q1 <= alu_f(alu_a_3, alu_b_3, alu_op_3);
        q2 <= q1;
        q3 <= q2;
    end
    assign alu_res    = p1[7:0];
    assign alu_xtra   = p1[8];
    assign alu_res_3  = q3[7:0];
    assign alu_xtra_3 = q3[8];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int n;
    bit seen;
    bit any_done;

    initial begin
        {req0, req1, req0_3, req1_3} = '0;
        {a0, b0, a1, b1, op0, op1} = '0;
        {a0_3, b0_3, a1_3, b1_3, op0_3, op1_3} = '0;
        #2;
        check("rst_gnt", {gnt0, gnt1, done0, done1, busy}, 0);
        check("rst_res", {carry, res, alu_a, alu_b, alu_op}, 0);
        check("rst_dut3", {gnt0_3, gnt1_3, done0_3, done1_3, busy_3, res_3}, 0);
        tick;
        rst_n = 1'b1;

        // Single add with carry out
        req0 = 1'b1; a0 = 8'd255; b0 = 8'd20; op0 = 3'd0;
        tick;
        check("s_gnt0_e0", {gnt0, gnt1, busy}, 3'b101);
        check("s_alu_a", alu_a, 255);
        req0 = 1'b0;
        tick;
        check("s_e1", {gnt0, done0}, 2'b10);
        tick;
        check("s_done_e2", {gnt0, done0, done1}, 3'b010);
        check("s_res", res, 19);
        check("s_carry", carry, 1);
        tick;
        check("s_e3", {done0, busy}, 0);
        check("s_res_hold", res, 19);

        // Reset restores priority to requester 0
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd7; op0 = 3'd1;
        req1 = 1'b1; a1 = 8'd23; b1 = 8'd12; op1 = 3'd5;
        tick;
        check("t_gnt_e0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        tick;
        tick;
        check("t_done0", {done0, done1, gnt0, gnt1}, 4'b1000);
        check("t_res0", {carry, res}, {1'b1, 8'd254});
        tick;
        tick;
        check("t_gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 1'b0;
        tick;
        tick;
        check("t_done1", {done0, done1}, 2'b01);
        check("t_res1", {carry, res}, {1'b0, 8'd4});

        // Continuous requests alternate strictly
        a0 = 8'd10; b0 = 8'd3; op0 = 3'd0;
        a1 = 8'd10; b1 = 8'd3; op1 = 3'd1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 12) begin
                tick;
                n++;
                check("rr_gnt_mutex", gnt0 & gnt1, 0);
                if (done0 | done1) seen = 1'b1;
            end
            if (k == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            check("rr_seen", seen, 1);
            check("rr_done_owner", {done0, done1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("rr_res", res, (k % 2 == 0) ? 13 : 7);
        end
        tick;
        check("rr_idle", busy, 0);

        // Asynchronous reset in the middle of EXEC
        req0 = 1'b1; a0 = 8'd1; b0 = 8'd1; op0 = 3'd0;
        tick;
        check("r_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("r_ctl_zero", {gnt0, gnt1, done0, done1, busy}, 0);
        check("r_dat_zero", {carry, res, alu_a, alu_b, alu_op}, 0);
        #1;
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (done0 | done1) any_done = 1'b1;
        end
        check("r_no_done", any_done, 0);
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd0; op0 = 3'd2;
        tick;
        req0 = 1'b0;
        n = 0;
        while (!done0 && n < 8) begin
            tick;
            n++;
        end
        check("r_after_done", done0, 1);
        check("r_after_res", res, 9);
        tick;

        // Inputs changed after grant do not alter the operation
        req0 = 1'b1; a0 = 8'd43; b0 = 8'd0; op0 = 3'd6;
        tick;
        check("h_gnt0", gnt0, 1);
        tick;
        a0 = 8'd0;
        req0 = 1'b0;
        tick;
        check("h_done0", done0, 1);
        check("h_res", {carry, res}, {1'b0, 8'd212});
        check("h_alu_a", alu_a, 43);

        // Longer ALU latency
        req1_3 = 1'b1; a1_3 = 8'd42; b1_3 = 8'd22; op1_3 = 3'd7;
        tick;
        check("l_gnt1", {gnt0_3, gnt1_3}, 2'b01);
        req1_3 = 1'b0;
        tick;
        tick;
        tick;
        check("l_e3", {done1_3, busy_3}, 2'b01);
        tick;
        check("l_done1", {done0_3, done1_3, gnt1_3}, 3'b010);
        check("l_res", {carry_3, res_3}, {1'b0, 8'd62});
        tick;
        check("l_e5", {done1_3, busy_3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
